cga_comp_sequencer: RTL and testbench
=====================================

CGA_COMP_SEQUENCER -- requirements
Module: cga_comp_sequencer

Interface
REQ-001 Parameter H_TOTAL, default 114, meaning character clocks per line.
REQ-002 Parameter H_DISP, default 80, meaning displayed characters per line.
REQ-003 Parameter H_SYNC_START, default 90, meaning first character of hsync.
REQ-004 Parameter H_SYNC_LEN, default 10, meaning hsync width in characters.
REQ-005 Parameter V_TOTAL, default 262, meaning lines per frame.
REQ-006 Parameter V_DISP, default 200, meaning displayed lines per frame.
REQ-007 Parameter V_SYNC_START, default 224, meaning first line of vsync.
REQ-008 Parameter V_SYNC_LEN, default 3, meaning vsync width in lines.
REQ-009 clk  input  1  28.636 MHz system clock; the only clock.
REQ-010 reset_n  input  1  asynchronous, active-low reset.
REQ-011 cfg_we  input  1  one-clk write strobe for the mode register.
REQ-012 cfg_data  input  8  mode value: bit3 video enable, bit2 bw_mode, others stored only.
REQ-013 hclk  output  1  one-clk character strobe.
REQ-014 lclk  output  1  one-clk half-rate character strobe.
REQ-015 hsync  output  1  active-high horizontal sync.
REQ-016 vsync_l  output  1  active-low vertical sync.
REQ-017 disp_en  output  1  active display window, gated by video enable.
REQ-018 h_char  output  7  current character column.
REQ-019 v_line  output  9  current line.
REQ-020 bw_mode  output  1  applied bw_mode bit, for the composite encoder.
REQ-021 frame_start  output  1  one-clk pulse at frame wrap.
REQ-022 mode_active  output  8  currently applied mode register.

Function
REQ-023 The 4-bit prescaler SHALL count 0..15 continuously; hclk SHALL be 1 exactly when the prescaler is 15, so the period is 16 clk.
REQ-024 lclk SHALL equal hclk AND h_char[0]==1, so the period is 32 clk.
REQ-025 On hclk, h_char SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and v_line SHALL increment.
REQ-026 v_line SHALL wrap from V_TOTAL-1 to 0 when h_char also wraps.
REQ-027 frame_start SHALL be 1 for the single clk in which both counters wrap.
REQ-028 Line period SHALL be H_TOTAL*16 clk; frame period SHALL be V_TOTAL*H_TOTAL*16 clk.
REQ-029 hsync SHALL be 1 iff H_SYNC_START <= h_char < H_SYNC_START+H_SYNC_LEN.
REQ-030 vsync_l SHALL be 0 iff V_SYNC_START <= v_line < V_SYNC_START+V_SYNC_LEN.
REQ-031 disp_en SHALL be 1 iff h_char < H_DISP, v_line < V_DISP, and mode_active[3]==1.
REQ-032 hsync, vsync_l, and disp_en SHALL be combinational decodes of the registered counters and mode_active, so there is zero latency from the counters.
REQ-033 A cfg_we write SHALL load a pending register and set a pending flag; it SHALL NOT change mode_active immediately.
REQ-034 Apply point: pending is set, the FSM is in WAIT_VSYNC, and the clk is the first with vsync_l low (v_line==V_SYNC_START, h_char==0, prescaler==0). At the apply point, mode_active SHALL take pending and pending SHALL clear.
REQ-035 FSM states:
- IDLE (pending clear) -> WAIT_VSYNC on cfg_we.
- WAIT_VSYNC -> IDLE at the apply point.
REQ-036 Multiple writes before the apply point SHALL be merged; the last value wins.
REQ-037 If cfg_we coincides with the apply point, cfg_data SHALL be applied directly and pending SHALL remain clear.
REQ-038 bw_mode SHALL equal mode_active[2].
REQ-039 Counters SHALL never exceed TOTAL-1; an out-of-range value (not reachable in normal operation) SHALL wrap to 0 on the next hclk.

Reset
REQ-040 While reset_n is 0, the following SHALL be 0: prescaler, h_char, v_line, pending, mode_active, and the FSM (IDLE).
REQ-041 Consequently, during reset: hclk=0, lclk=0, hsync=0, vsync_l=1, disp_en=0, bw_mode=0, frame_start=0.
REQ-042 Reset asserted mid-frame SHALL discard any pending write.
REQ-043 Counting SHALL resume from 0 on the first clk after deassertion.

Verification
REQ-044 Release reset, free-run:
- First hclk at clk 16, then every 16 clk.
- lclk every 32 clk.
- hsync high for 160 clk per 1824-clk line.
- frame_start period 477888 clk.
REQ-045 Write cfg_data=0x08 mid-frame at v_line 50 -> disp_en stays 0 until the vsync apply point at v_line 224; in the next frame, disp_en is high for h_char 0..79 on lines 0..199.
REQ-046 Write 0x04 then 0x0C within one frame -> at the apply point mode_active=0x0C, bw_mode=1, pending clear.
REQ-047 Pulse cfg_we=0x04 exactly at the apply point -> mode_active=0x04 the same cycle; FSM stays IDLE.
REQ-048 Write 0x0C, then assert reset_n=0 before vsync -> after release, mode_active=0x00, vsync_l=1, disp_en=0; no later apply occurs.
REQ-049 Check vsync_l is low exactly on lines 224..226 (3*1824 clk), and hsync/vsync_l/disp_en decodes hold at h_char=113→0 and v_line=261→0 wrap boundaries.

Source files
------------

// File: rtl/cga_comp_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : cga_comp_sequencer_if
//  Purpose  : Mode-register write port and video timing outputs of the CGA sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface cga_comp_sequencer_if;
    logic       cfg_we;
    logic [7:0] cfg_data;
    logic       hclk;
    logic       lclk;
    logic       hsync;
    logic       vsync_l;
    logic       disp_en;
    logic [6:0] h_char;
    logic [8:0] v_line;
    logic       bw_mode;
    logic       frame_start;
    logic [7:0] mode_active;

    modport master (
        output cfg_we, cfg_data,
        input  hclk, lclk, hsync, vsync_l, disp_en, h_char, v_line,
        input  bw_mode, frame_start, mode_active
    );

    modport slave (
        input  cfg_we, cfg_data,
        output hclk, lclk, hsync, vsync_l, disp_en, h_char, v_line,
        output bw_mode, frame_start, mode_active
    );
endinterface
`default_nettype wire

// File: rtl/cga_comp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cga_comp_sequencer
//  Purpose  : CGA character/line timing generator with a mode register applied at vsync.
//  Revision : 1.0  initial release
// ============================================================================
module cga_comp_sequencer #(
    parameter int H_TOTAL      = 114,
    parameter int H_DISP       = 80,
    parameter int H_SYNC_START = 90,
    parameter int H_SYNC_LEN   = 10,
    parameter int V_TOTAL      = 262,
    parameter int V_DISP       = 200,
    parameter int V_SYNC_START = 224,
    parameter int V_SYNC_LEN   = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cga_comp_sequencer_if.slave  bus
);

    localparam logic [6:0] c_h_last     = 7'(H_TOTAL - 1);
    localparam logic [6:0] c_h_disp     = 7'(H_DISP);
    localparam logic [6:0] c_hs_start   = 7'(H_SYNC_START);
    localparam logic [6:0] c_hs_end     = 7'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [8:0] c_v_last     = 9'(V_TOTAL - 1);
    localparam logic [8:0] c_v_disp     = 9'(V_DISP);
    localparam logic [8:0] c_vs_start   = 9'(V_SYNC_START);
    localparam logic [8:0] c_vs_end     = 9'(V_SYNC_START + V_SYNC_LEN);

    typedef enum logic [0:0] {
        ST_IDLE       = 1'b0,
        ST_WAIT_VSYNC = 1'b1
    } state_t;

    logic [3:0] r_prescale;
    logic [6:0] r_h_char;
    logic [8:0] r_v_line;
    logic [7:0] r_pending;
    logic       r_pending_valid;
    logic [7:0] r_mode;
    state_t     r_state;

    logic w_hclk;
    logic w_h_wrap;
    logic w_v_wrap;
    logic w_apply_time;

    // Wrap compares use >= so a corrupted counter recovers on the next strobe.
    assign w_hclk       = (r_prescale == 4'hF);
    assign w_h_wrap     = w_hclk && (r_h_char >= c_h_last);
    assign w_v_wrap     = w_h_wrap && (r_v_line >= c_v_last);
    assign w_apply_time = (r_v_line == c_vs_start) && (r_h_char == 7'd0) && (r_prescale == 4'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prescale <= 4'd0;
            r_h_char   <= 7'd0;
            r_v_line   <= 9'd0;
        end else begin
            r_prescale <= r_prescale + 4'd1;
            if (w_hclk) begin
                if (w_h_wrap) begin
                    r_h_char <= 7'd0;
                    r_v_line <= w_v_wrap ? 9'd0 : r_v_line + 9'd1;
                end else begin
                    r_h_char <= r_h_char + 7'd1;
                end
            end
        end
    end

    // A write landing on the apply cycle bypasses the pending register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_pending       <= 8'd0;
            r_pending_valid <= 1'b0;
            r_mode          <= 8'd0;
        end else begin
            if (bus.cfg_we && w_apply_time) begin
                r_mode          <= bus.cfg_data;
                r_pending_valid <= 1'b0;
                r_state         <= ST_IDLE;
            end else if (bus.cfg_we) begin
                r_pending       <= bus.cfg_data;
                r_pending_valid <= 1'b1;
                r_state         <= ST_WAIT_VSYNC;
            end else if (r_state == ST_WAIT_VSYNC && w_apply_time) begin
                r_mode          <= r_pending;
                r_pending_valid <= 1'b0;
                r_state         <= ST_IDLE;
            end
        end
    end

    assign bus.hclk        = w_hclk;
    assign bus.lclk        = w_hclk & r_h_char[0];
    assign bus.hsync       = (r_h_char >= c_hs_start) && (r_h_char < c_hs_end);
    assign bus.vsync_l     = !((r_v_line >= c_vs_start) && (r_v_line < c_vs_end));
    assign bus.disp_en     = (r_h_char < c_h_disp) && (r_v_line < c_v_disp) && r_mode[3];
    assign bus.h_char      = r_h_char;
    assign bus.v_line      = r_v_line;
    assign bus.bw_mode     = r_mode[2];
    assign bus.frame_start = w_v_wrap;
    assign bus.mode_active = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_cga_comp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cga_comp_sequencer
//  Purpose  : Directed self-checking bench for cga_comp_sequencer on a reduced raster.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cga_comp_sequencer;

    localparam int HT = 20, HD = 12, HSS = 14, HSL = 3;
    localparam int VT = 16, VD = 10, VSS = 12, VSL = 2;
    localparam int LINE  = 16 * HT;
    localparam int FRAME = LINE * VT;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int t        = 0;
    int trk_err  = 0;
    logic [7:0] exp_mode = 8'h00;
    int n_hclk, n_lclk, n_hs, n_vsl, n_de, n_fs, first_fs, last_fs, first_hclk;

    cga_comp_sequencer_if ifc ();

    cga_comp_sequencer #(
        .H_TOTAL(HT), .H_DISP(HD), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
        .V_TOTAL(VT), .V_DISP(VD), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_hclk = 0; n_lclk = 0; n_hs = 0; n_vsl = 0; n_de = 0; n_fs = 0;
        first_fs = -1; last_fs = -1; first_hclk = -1;
    endtask

    // Advance one clock; expected raster position follows from edges since reset release.
    task automatic run1();
        int p, hc, vl;
        logic e_hclk, e_lclk, e_hs, e_vsl, e_de, e_fs;
        @(posedge clk);
        t++;
        #1;
        p  = t % 16;
        hc = (t / 16) % HT;
        vl = (t / LINE) % VT;
        e_hclk = (p == 15);
        e_lclk = e_hclk && (hc % 2 == 1);
        e_hs   = (hc >= HSS) && (hc < HSS + HSL);
        e_vsl  = !((vl >= VSS) && (vl < VSS + VSL));
        e_de   = (hc < HD) && (vl < VD) && exp_mode[3];
        e_fs   = e_hclk && (hc == HT - 1) && (vl == VT - 1);
        if (ifc.h_char !== 7'(hc) || ifc.v_line !== 9'(vl) || ifc.hclk !== e_hclk ||
            ifc.lclk !== e_lclk || ifc.hsync !== e_hs || ifc.vsync_l !== e_vsl ||
            ifc.disp_en !== e_de || ifc.frame_start !== e_fs ||
            ifc.mode_active !== exp_mode || ifc.bw_mode !== exp_mode[2])
            trk_err++;
        if (ifc.hclk === 1'b1) begin
            n_hclk++;
            if (first_hclk < 0) first_hclk = t;
        end
        if (ifc.lclk === 1'b1)     n_lclk++;
        if (ifc.hsync === 1'b1)    n_hs++;
        if (ifc.vsync_l === 1'b0)  n_vsl++;
        if (ifc.disp_en === 1'b1)  n_de++;
        if (ifc.frame_start === 1'b1) begin
            n_fs++;
            if (first_fs < 0) first_fs = t;
            last_fs = t;
        end
    endtask

    task automatic run_to(input int target);
        while (t < target) run1();
    endtask

    task automatic cfg_write(input logic [7:0] d);
        ifc.cfg_we   = 1'b1;
        ifc.cfg_data = d;
        run1();
        ifc.cfg_we   = 1'b0;
        ifc.cfg_data = 8'h00;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifc.cfg_we   = 1'b0;
        ifc.cfg_data = 8'h00;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check("rst_h_char",  ifc.h_char, 0);
        check("rst_v_line",  ifc.v_line, 0);
        check("rst_hclk",    ifc.hclk, 0);
        check("rst_lclk",    ifc.lclk, 0);
        check("rst_hsync",   ifc.hsync, 0);
        check("rst_vsync_l", ifc.vsync_l, 1);
        check("rst_disp_en", ifc.disp_en, 0);
        check("rst_bw_mode", ifc.bw_mode, 0);
        check("rst_fs",      ifc.frame_start, 0);
        check("rst_mode",    ifc.mode_active, 0);

        // Free run over two frames
        reset_n = 1'b1;
        t = 0;
        run_to(2 * FRAME);
        check("trk_free",     trk_err, 0);
        check("first_hclk",   first_hclk, 15);
        check("hclk_cnt",     n_hclk, 2 * FRAME / 16);
        check("lclk_cnt",     n_lclk, FRAME / 16);
        check("hsync_cnt",    n_hs, 2 * VT * HSL * 16);
        check("vsync_lo_cnt", n_vsl, 2 * VSL * LINE);
        check("fs_cnt",       n_fs, 2);
        check("fs_first",     first_fs, FRAME - 1);
        check("fs_period",    last_fs - first_fs, FRAME);
        check("de_off_cnt",   n_de, 0);
        trk_err = 0;

        // Enable video mid-frame; takes effect only at the vsync apply point
        run_to(2 * FRAME + 5 * LINE + 100);
        cfg_write(8'h08);
        run_to(2 * FRAME + VSS * LINE);
        check("en_pre_mode", ifc.mode_active, 8'h00);
        check("en_pre_pend", dut.r_pending_valid, 1);
        exp_mode = 8'h08;
        run1();
        check("en_mode",     ifc.mode_active, 8'h08);
        check("en_pend_clr", dut.r_pending_valid, 0);
        run_to(3 * FRAME);
        check("trk_enable", trk_err, 0);
        trk_err = 0;
        clear_stats();
        run_to(3 * FRAME + 11 * 16);
        check("de_h11", ifc.disp_en, 1);
        run_to(3 * FRAME + 12 * 16);
        check("de_h12", ifc.disp_en, 0);
        run_to(3 * FRAME + 9 * LINE + 5);
        check("de_v9", ifc.disp_en, 1);
        run_to(3 * FRAME + 10 * LINE + 5);
        check("de_v10", ifc.disp_en, 0);
        run_to(4 * FRAME);
        check("de_cnt", n_de, HD * 16 * VD);
        check("trk_disp", trk_err, 0);
        trk_err = 0;

        // Two writes in one frame merge; last one wins
        run_to(4 * FRAME + 3 * LINE);
        cfg_write(8'h04);
        run_to(4 * FRAME + 6 * LINE);
        cfg_write(8'h0C);
        run_to(4 * FRAME + VSS * LINE);
        check("mrg_pre_mode", ifc.mode_active, 8'h08);
        check("mrg_pre_pend", dut.r_pending_valid, 1);
        exp_mode = 8'h0C;
        run1();
        check("mrg_mode",     ifc.mode_active, 8'h0C);
        check("mrg_bw",       ifc.bw_mode, 1);
        check("mrg_pend_clr", dut.r_pending_valid, 0);

        // Write exactly on the apply cycle goes straight to the mode register
        run_to(5 * FRAME + VSS * LINE);
        exp_mode = 8'h04;
        cfg_write(8'h04);
        check("dir_mode",  ifc.mode_active, 8'h04);
        check("dir_pend",  dut.r_pending_valid, 0);
        check("dir_bw",    ifc.bw_mode, 1);
        check("dir_de",    ifc.disp_en, 0);
        check("trk_modes", trk_err, 0);
        trk_err = 0;

        // Reset before vsync discards a pending write
        run_to(6 * FRAME + 2 * LINE);
        cfg_write(8'h0C);
        run_to(6 * FRAME + 4 * LINE + 7);
        check("rr_pend_pre", dut.r_pending_valid, 1);
        reset_n = 1'b0;
        #1;
        check("rr_async_h",    ifc.h_char, 0);
        check("rr_async_mode", ifc.mode_active, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        t        = 0;
        exp_mode = 8'h00;
        check("rr_vsync_l", ifc.vsync_l, 1);
        check("rr_disp_en", ifc.disp_en, 0);
        check("rr_pend",    dut.r_pending_valid, 0);
        check("rr_v_line",  ifc.v_line, 0);
        run_to(FRAME + VSS * LINE + 2);
        check("rr_no_apply", ifc.mode_active, 8'h00);
        check("trk_reset",   trk_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
